// File: rtl/regbank_scan_4x4b.sv
// regbank_scan_4x4b
//
// This block is a 4-entry x 4-bit register bank with a built-in select
// sequencer. It feeds a 4-bit 4:1 datapath mux. q0..q3 drive the mux data
// inputs, and sel drives the mux select.
//
// The host loads entries through a single write port and then starts a scan.
// During a scan, sel steps through 0..3 and holds each value for DWELL cycles.
// A scan is either one-shot or continuous.
//
// Parameters:
//   DWELL      cycles each sel value is held during a scan (1..16)
//   RESET_VAL  value loaded into all four entries on reset
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   wr_en       write strobe
//   wr_addr     entry written when wr_en=1
//   wr_data     write data
//   scan_start  starts a scan (only looked at while idle)
//   scan_cont   continuous mode (only looked at on the wrap from sel=3)
//   scan_stop   aborts an active scan
//   q0..q3      register contents
//   par         per-entry even parity (only with REGBANK_PARITY_EN)
//   sel         mux select
//   scan_busy   high while scanning
//   scan_done   one-cycle pulse after each completed pass
//
// Optional feature macro: REGBANK_PARITY_EN adds the registered par output.

module regbank_scan_4x4b #(
    parameter int         DWELL     = 1,
    parameter logic [3:0] RESET_VAL = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       scan_start,
    input  logic       scan_cont,
    input  logic       scan_stop,
    output logic [3:0] q0,
    output logic [3:0] q1,
    output logic [3:0] q2,
    output logic [3:0] q3,
`ifdef REGBANK_PARITY_EN
    output logic [3:0] par,
`endif
    output logic [1:0] sel,
    output logic       scan_busy,
    output logic       scan_done
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // The dwell counter is 4 bits wide, so DWELL=16 gives a terminal count of 15.
    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

    logic [3:0] regs [4];
    state_t     state;
    state_t     state_nxt;
    logic [1:0] sel_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       done_nxt;

    // The register bank. Writes are independent of the sequencer and are
    // accepted in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign q0 = regs[0];
    assign q1 = regs[1];
    assign q2 = regs[2];
    assign q3 = regs[3];

`ifdef REGBANK_PARITY_EN
    // Parity is captured from wr_data on the same edge as the entry itself,
    // so par and q always change together.
    logic [3:0] par_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_r <= {4{^RESET_VAL}};
        end else if (wr_en) begin
            par_r[wr_addr] <= ^wr_data;
        end
    end

    assign par = par_r;
`endif

    // These are the sequencer state registers. Every output is taken directly
    // from one of these flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= 2'd0;
            cnt       <= 4'd0;
            scan_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            cnt       <= cnt_nxt;
            scan_done <= done_nxt;
        end
    end

    assign scan_busy = (state == SCAN);

    // Next-state logic. scan_stop is tested before the dwell/wrap logic, so an
    // abort that lands on the wrap edge never produces a scan_done pulse.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                sel_nxt = 2'd0;
                cnt_nxt = 4'd0;
                if (scan_start) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (scan_stop) begin
                    state_nxt = IDLE;
                    sel_nxt   = 2'd0;
                    cnt_nxt   = 4'd0;
                end else if (cnt == DWELL_LAST) begin
                    cnt_nxt = 4'd0;
                    sel_nxt = sel + 2'd1;
                    if (sel == 2'd3) begin
                        done_nxt = 1'b1;
                        if (!scan_cont) begin
                            state_nxt = IDLE;
                        end
                    end
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = 2'd0;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_regbank_scan_4x4b.sv
// tb_regbank_scan_4x4b
//
// This is the testbench for regbank_scan_4x4b. It instantiates two copies of
// the design:
//   u_dut1  DWELL=1
//   u_dut3  DWELL=3
// The two copies share the clock, the reset and the write port. Each copy has
// its own scan controls.
//
// Expected outputs are pushed onto a scoreboard queue when a vector is
// driven. They are popped and compared one clock later, on the falling edge.

module tb_regbank_scan_4x4b;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic       start1, cont1, stop1;
    logic       start3, cont3, stop3;

    logic [3:0] q0_1, q1_1, q2_1, q3_1;
    logic [1:0] sel_1;
    logic       busy_1, done_1;
    logic [3:0] q0_3, q1_3, q2_3, q3_3;
    logic [1:0] sel_3;
    logic       busy_3, done_3;
`ifdef REGBANK_PARITY_EN
    logic [3:0] par_1, par_3;
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        wr_en;
        logic [1:0]  wr_addr;
        logic [3:0]  wr_data;
        logic        start;
        logic        cont;
        logic        stop;
        logic [15:0] q;      // {q0,q1,q2,q3}
        logic [1:0]  sel;
        logic        busy;
        logic        done;
    } vec_t;

    typedef struct {
        int          dut;
        string       tag;
        logic [15:0] q;
        logic [1:0]  sel;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[$];

    regbank_scan_4x4b #(.DWELL(1), .RESET_VAL(4'b0000)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .scan_start(start1), .scan_cont(cont1), .scan_stop(stop1),
        .q0(q0_1), .q1(q1_1), .q2(q2_1), .q3(q3_1),
`ifdef REGBANK_PARITY_EN
        .par(par_1),
`endif
        .sel(sel_1), .scan_busy(busy_1), .scan_done(done_1)
    );

    regbank_scan_4x4b #(.DWELL(3), .RESET_VAL(4'b0000)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .scan_start(start3), .scan_cont(cont3), .scan_stop(stop3),
        .q0(q0_3), .q1(q1_3), .q2(q2_3), .q3(q3_3),
`ifdef REGBANK_PARITY_EN
        .par(par_3),
`endif
        .sel(sel_3), .scan_busy(busy_3), .scan_done(done_3)
    );

    // Free-running clock with a 10-time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds a single vector record.
    function automatic vec_t mk(input logic we, input logic [1:0] a, input logic [3:0] d,
                                input logic st, input logic co, input logic sp,
                                input logic [15:0] eq, input logic [1:0] es,
                                input logic eb, input logic ed);
        vec_t v;
        v.wr_en = we;  v.wr_addr = a;  v.wr_data = d;
        v.start = st;  v.cont = co;    v.stop = sp;
        v.q = eq;      v.sel = es;     v.busy = eb;  v.done = ed;
        return v;
    endfunction

    // Compares one observed value against its expected value and counts the result.
    task automatic checkValue(input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one vector onto the chosen DUT's controls and queues the
    // outputs expected after the next rising edge.
    task automatic applyStimulus(input int dut, input string tag, input vec_t v);
        exp_t e;
        wr_en   = v.wr_en;
        wr_addr = v.wr_addr;
        wr_data = v.wr_data;
        start1  = (dut == 1) ? v.start : 1'b0;
        cont1   = (dut == 1) ? v.cont  : 1'b0;
        stop1   = (dut == 1) ? v.stop  : 1'b0;
        start3  = (dut == 3) ? v.start : 1'b0;
        cont3   = (dut == 3) ? v.cont  : 1'b0;
        stop3   = (dut == 3) ? v.stop  : 1'b0;
        e.dut  = dut;
        e.tag  = tag;
        e.q    = v.q;
        e.sel  = v.sel;
        e.busy = v.busy;
        e.done = v.done;
        sbq.push_back(e);
    endtask

    // Pops the oldest expectation and compares it with the live outputs.
    task automatic checkOutput();
        exp_t        e;
        logic [15:0] aq;
        logic [1:0]  asel;
        logic        abusy, adone;
        if (sbq.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sbq.pop_front();
        if (e.dut == 1) begin
            aq = {q0_1, q1_1, q2_1, q3_1}; asel = sel_1; abusy = busy_1; adone = done_1;
        end else begin
            aq = {q0_3, q1_3, q2_3, q3_3}; asel = sel_3; abusy = busy_3; adone = done_3;
        end
        checkValue({e.tag, " q"},    aq, e.q);
        checkValue({e.tag, " sel"},  {14'd0, asel}, {14'd0, e.sel});
        checkValue({e.tag, " busy"}, {15'd0, abusy}, {15'd0, e.busy});
        checkValue({e.tag, " done"}, {15'd0, adone}, {15'd0, e.done});
`ifdef REGBANK_PARITY_EN
        checkValue({e.tag, " par"}, {12'd0, (e.dut == 1) ? par_1 : par_3},
                   {12'd0, ^e.q[3:0], ^e.q[7:4], ^e.q[11:8], ^e.q[15:12]});
`endif
    endtask

    // The caller must be at a falling edge. This drives the vector, lets one
    // rising edge pass, and checks at the following falling edge.
    task automatic runVector(input int dut, input string tag, input vec_t v);
        applyStimulus(dut, tag, v);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        vec_t v;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'd0;
        start1 = 1'b0; cont1 = 1'b0; stop1 = 1'b0;
        start3 = 1'b0; cont3 = 1'b0; stop3 = 1'b0;

        // The expected outputs in this table are for DWELL=1.
        // Field order: wr_en, wr_addr, wr_data, start, cont, stop,
        //              {q0,q1,q2,q3}, sel, busy, done
        tbl.push_back(mk(1'b1, 2'd0, 4'hA, 1'b0, 1'b0, 1'b0, 16'hA000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 2'd1, 4'h5, 1'b0, 1'b0, 1'b0, 16'hA500, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 2'd2, 4'hC, 1'b0, 1'b0, 1'b0, 16'hA5C0, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 2'd3, 4'h3, 1'b0, 1'b0, 1'b0, 16'hA5C3, 2'd0, 1'b0, 1'b0));
        // One-shot pass.
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0, 16'hA5C3, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 2'd0, 1'b0, 1'b0));
        // scan_stop while idle does nothing.
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b1, 16'hA5C3, 2'd0, 1'b0, 1'b0));
        // start together with stop: start wins.
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 1'b1, 16'hA5C3, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 2'd2, 1'b1, 1'b0));
        // Stop while sel=2.
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b1, 16'hA5C3, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 2'd0, 1'b0, 1'b0));
        // Stop on the wrap edge, with scan_cont=1 as well: no done pulse.
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0, 16'hA5C3, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b1, 16'hA5C3, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 2'd0, 1'b0, 1'b0));
        // Continuous mode for two passes. scan_start during SCAN is ignored.
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b1, 1'b1, 1'b0, 16'hA5C3, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0, 16'hA5C3, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0, 16'hA5C3, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0, 16'hA5C3, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b1, 1'b0, 16'hA5C3, 2'd0, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b1, 1'b0, 1'b0, 16'hA5C3, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 16'hA5C3, 2'd0, 1'b0, 1'b0));

        // Check the outputs while reset is asserted.
        #12;
        checkValue("reset q dut1",    {q0_1, q1_1, q2_1, q3_1}, 16'h0000);
        checkValue("reset q dut3",    {q0_3, q1_3, q2_3, q3_3}, 16'h0000);
        checkValue("reset sel dut1",  {14'd0, sel_1}, 16'd0);
        checkValue("reset busy dut1", {15'd0, busy_1}, 16'd0);
        checkValue("reset done dut1", {15'd0, done_1}, 16'd0);
`ifdef REGBANK_PARITY_EN
        checkValue("reset par dut1",  {12'd0, par_1}, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] table vectors, DWELL=1");
        for (int i = 0; i < tbl.size(); i++) begin
            runVector(1, $sformatf("vec%0d", i), tbl[i]);
        end

        // With DWELL=3 and continuous mode, scan_done pulses every 12 cycles.
        // scan_cont is dropped before the third wrap, so that wrap ends the scan.
        // A write to addr 2 at cycle 7 must not disturb the sel timing.
        $display("[TB] continuous scan, DWELL=3");
        for (int k = 0; k <= 37; k++) begin
            v = mk(k == 7, 2'd2, 4'h9, k == 0, k < 30, 1'b0,
                   (k >= 7) ? 16'hA593 : 16'hA5C3,
                   (k < 36) ? 2'((k / 3) % 4) : 2'd0,
                   k < 36, (k > 0) && (k % 12 == 0));
            runVector(3, $sformatf("d3 k%0d", k), v);
        end

        // Asynchronous reset in the middle of a scan, while sel=2.
        $display("[TB] asynchronous reset mid-scan");
        for (int k = 0; k <= 6; k++) begin
            v = mk(1'b0, 2'd0, 4'h0, k == 0, 1'b1, 1'b0, 16'hA593,
                   2'((k / 3) % 4), 1'b1, 1'b0);
            runVector(3, $sformatf("rst k%0d", k), v);
        end
        start3 = 1'b0; cont3 = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkValue("async sel",  {14'd0, sel_3}, 16'd0);
        checkValue("async busy", {15'd0, busy_3}, 16'd0);
        checkValue("async done", {15'd0, done_3}, 16'd0);
        checkValue("async q",    {q0_3, q1_3, q2_3, q3_3}, 16'h0000);
        #4 rst_n = 1'b1;
        @(negedge clk);
        checkValue("post-reset sel",  {14'd0, sel_3}, 16'd0);
        checkValue("post-reset busy", {15'd0, busy_3}, 16'd0);
        checkValue("post-reset done", {15'd0, done_3}, 16'd0);

`ifdef REGBANK_PARITY_EN
        $display("[TB] parity");
        runVector(1, "par odd", mk(1'b1, 2'd1, 4'b0111, 1'b0, 1'b0, 1'b0, 16'h0700, 2'd0, 1'b0, 1'b0));
        checkValue("par1 odd", {15'd0, par_1[1]}, 16'd1);
        runVector(1, "par even", mk(1'b1, 2'd1, 4'b0110, 1'b0, 1'b0, 1'b0, 16'h0600, 2'd0, 1'b0, 1'b0));
        checkValue("par1 even", {15'd0, par_1[1]}, 16'd0);
`endif

        if (sbq.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard leftover: got %0d expected 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regbank_scan_4x4b.md
Name: regbank_scan_4x4b

Overview:
- 4-entry x 4-bit register bank with a built-in select sequencer.
- Sits directly upstream of the 4-bit 4x1 datapath mux:
  - q0..q3 drive the mux data inputs i0..i3.
  - sel drives the mux select s.
- Host writes entries through a single write port, then starts a scan. The scan steps sel through 0..3, holding each value for DWELL cycles.
- A one-shot or continuous scan presents the registers in sequence at the mux output.

Parameters:
- DWELL, 1, cycles each sel value is held during a scan. Legal range 1..16; 4-bit dwell counter.
- RESET_VAL, 4'b0000, value loaded into all four registers on reset.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe for the register bank.
- wr_addr  input  2  entry written when wr_en=1.
- wr_data  input  4  write data.
- scan_start  input  1  starts a scan; sampled only in IDLE.
- scan_cont  input  1  continuous mode; sampled at each wrap from sel=3.
- scan_stop  input  1  aborts an active scan.
- q0, q1, q2, q3  output  4 each  register contents, to mux i0..i3.
- sel  output  2  select value, to mux s.
- scan_busy  output  1  high while in SCAN.
- scan_done  output  1  one-cycle pulse at the end of each completed pass.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - q0..q3 = RESET_VAL; sel = 0; scan_busy = 0; scan_done = 0.
  - FSM = IDLE; dwell counter = 0.
- Write: wr_en=1 at an edge loads wr_data into entry wr_addr. The new value is visible on q<addr> one cycle later. Writes are allowed in any state and do not disturb the sequencer.
- FSM states: IDLE, SCAN.
- IDLE:
  - sel is held at 0; scan_busy=0.
  - scan_start=1 -> SCAN next cycle, with sel=0, dwell counter=0, scan_busy=1.
- SCAN:
  - Dwell counter increments each cycle.
  - When counter = DWELL-1: counter clears and sel increments. DWELL=1 means sel advances every cycle.
  - At the final dwell cycle of sel=3, sel wraps to 0 and scan_done=1 for exactly that next cycle.
  - At wrap, scan_cont=1 -> stay in SCAN, starting a new pass.
  - At wrap, scan_cont=0 -> go to IDLE; scan_busy drops in the same cycle that scan_done is asserted.
- Timing: one pass with DWELL=D takes 4*D cycles from the scan_busy rising edge to the scan_done pulse.
- scan_stop=1 in SCAN:
  - Next cycle: IDLE, sel=0, scan_busy=0, scan_done stays 0, counter=0.
  - scan_stop has priority over a wrap occurring on the same edge.
  - scan_stop in IDLE has no effect.
- scan_start in SCAN is ignored. scan_start and scan_stop together in IDLE: start wins.
- Reset during SCAN aborts immediately to the reset values; no scan_done pulse.
- All outputs are registered; no combinational path from any input to any output.

Optional Feature:
- Macro REGBANK_PARITY_EN.
- Defined:
  - Adds output port par, 4 bits. par[n] = even parity (XOR reduction) of entry n.
  - par is registered and updates in the same cycle as the q it covers.
  - Reset value is the parity of RESET_VAL.
- Undefined: par port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then write 4'hA, 4'h5, 4'hC, 4'h3 to addrs 0..3 -> q0..q3 = A,5,C,3 one cycle after each write; sel=0; scan_busy=0.
- DWELL=1, one-shot: pulse scan_start with scan_cont=0 -> sel = 0,1,2,3 on consecutive cycles; then scan_done=1 for one cycle with sel=0 and scan_busy=0.
- DWELL=3, scan_cont=1 held: sel holds each value 3 cycles; scan_done pulses every 12 cycles; scan_busy stays 1; a write to addr 2 mid-scan updates q2 without affecting sel timing.
- scan_stop asserted while sel=2 -> next cycle IDLE, sel=0, scan_busy=0, no scan_done; scan_stop asserted on the wrap edge also yields no scan_done.
- rst_n pulled low for half a cycle mid-scan -> all outputs return to reset values immediately, without waiting for clk.
- With REGBANK_PARITY_EN, write 4'b0111 to addr 1 -> par[1]=1 next cycle; write 4'b0110 -> par[1]=0.
